// File: rtl/ro_adc_ctrl.sv
// Ring-oscillator ADC conversion controller: enable oscillator, settle, count synchronized
// comparator rising edges over a gate window, then hold the code on a valid/ready handshake.
module ro_adc_ctrl #(
   parameter int CNT_W      = 12,
   parameter int WIN_W      = 10,
   parameter int SETTLE_CYC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic             cmp_in,
   output logic             ro_en,
   output logic             busy,
   output logic [CNT_W-1:0] result,
   output logic             valid,
   input  logic             ready,
   output logic             ovf
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state_q,   state_d;
   logic [2:0]         sync_q,    sync_d;
   logic [WIN_W-1:0]   win_q,     win_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [CNT_W-1:0]   result_q,  result_d;
   logic               ovf_q,     ovf_d;
   logic               valid_q,   valid_d;
   logic               ro_en_q,   ro_en_d;
   logic               busy_q,    busy_d;
   logic               rise_pls;

   // sync_q[1:0] is the two-flop synchronizer; sync_q[2] is the edge-detect history flop.
   assign rise_pls = sync_q[1] & ~sync_q[2];

   always_comb begin
      state_d   = state_q;
      sync_d    = {sync_q[1:0], cmp_in};
      win_d     = win_q;
      win_cnt_d = win_cnt_q;
      set_cnt_d = set_cnt_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      ro_en_d   = ro_en_q;
      busy_d    = busy_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SETTLE;
               win_d     = win_len;
               cnt_d     = '0;
               ovf_d     = 1'b0;
               ro_en_d   = 1'b1;
               busy_d    = 1'b1;
               set_cnt_d = SET_W'(SETTLE_CYC - 1);
            end
         end
         SETTLE: begin
            if (set_cnt_q == '0) begin
               win_cnt_d = win_q;
               state_d   = (win_q == '0) ? DONE : MEASURE;
            end else begin
               set_cnt_d = set_cnt_q - SET_W'(1);
            end
         end
         MEASURE: begin
            if (rise_pls) begin
               if (cnt_q == {CNT_W{1'b1}}) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            if (win_cnt_q == WIN_W'(1)) begin
               state_d = DONE;
            end else begin
               win_cnt_d = win_cnt_q - WIN_W'(1);
            end
         end
         DONE: begin
            // First DONE cycle publishes the final count; afterwards wait for the consumer.
            if (!valid_q) begin
               valid_d  = 1'b1;
               ro_en_d  = 1'b0;
               result_d = cnt_q;
            end else if (ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sync_q    <= '0;
         win_q     <= '0;
         win_cnt_q <= '0;
         set_cnt_q <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         ro_en_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         win_q     <= win_d;
         win_cnt_q <= win_cnt_d;
         set_cnt_q <= set_cnt_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         ro_en_q   <= ro_en_d;
         busy_q    <= busy_d;
      end
   end

   assign ro_en  = ro_en_q;
   assign busy   = busy_q;
   assign result = result_q;
   assign valid  = valid_q;
   assign ovf    = ovf_q;

endmodule
